// File: rtl/hazard_scoreboard_if.sv
// Decode/Execute hazard bus: pipeline register fields in, stall/flush/forward controls out.
// The pipeline side uses master; the scoreboard uses slave.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       RA1E;
    logic [3:0]       RA2E;
    logic [3:0]       RdE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             PCSrcE;
    logic             CntClr;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, RdE, RegWriteE, MemtoRegE, PCSrcE, CntClr,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, RdE, RegWriteE, MemtoRegE, PCSrcE, CntClr,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks E->M->W destinations, issues load-use stalls,
// redirect flushes and forwarding selects, with saturating event counters.
module hazard_scoreboard #(
    parameter int         CNT_W  = 16,
    parameter logic [3:0] PC_REG = 4'd15
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave hz
);
    logic             validE_q;
    logic             bubbleE_q;
    logic [3:0]       RdM_q;
    logic             RegWriteM_q;
    logic [3:0]       RdW_q;
    logic             RegWriteW_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic qE, wrE, ldE, brE, ldStall;

    // The E register holds stale/undefined control bits after reset and after a flush,
    // so every raw E control is qualified before use.
    assign qE  = validE_q & ~bubbleE_q;
    assign wrE = hz.RegWriteE & qE;
    assign ldE = hz.MemtoRegE & qE;
    assign brE = hz.PCSrcE & qE;

    assign ldStall = ldE & ((hz.RdE == hz.RA1D) | (hz.RdE == hz.RA2D));

    function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
        if (ra == PC_REG)                    return 2'b00;
        else if (RegWriteM_q && RdM_q == ra) return 2'b10;
        else if (RegWriteW_q && RdW_q == ra) return 2'b01;
        else                                 return 2'b00;
    endfunction

    assign hz.ForwardAE  = fwd_sel(hz.RA1E);
    assign hz.ForwardBE  = fwd_sel(hz.RA2E);
    assign hz.StallF     = ldStall;
    assign hz.StallD     = ldStall;
    assign hz.FlushD     = brE;
    assign hz.FlushE     = ldStall | brE;
    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (ldStall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (brE && flush_cnt_q != '1)     flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validE_q    <= 1'b0;
            bubbleE_q   <= 1'b0;
            RdM_q       <= '0;
            RegWriteM_q <= 1'b0;
            RdW_q       <= '0;
            RegWriteW_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            validE_q    <= 1'b1;
            bubbleE_q   <= ldStall | brE;
            RdM_q       <= hz.RdE;
            RegWriteM_q <= wrE;
            RdW_q       <= RdM_q;
            RegWriteW_q <= RegWriteM_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic,
// checked against a queue-of-retired-writes reference model through a scoreboard.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(16)) ifa ();
    hazard_scoreboard_if #(.CNT_W(2))  ifb ();

    assign ifb.RA1D      = ifa.RA1D;
    assign ifb.RA2D      = ifa.RA2D;
    assign ifb.RA1E      = ifa.RA1E;
    assign ifb.RA2E      = ifa.RA2E;
    assign ifb.RdE       = ifa.RdE;
    assign ifb.RegWriteE = ifa.RegWriteE;
    assign ifb.MemtoRegE = ifa.MemtoRegE;
    assign ifb.PCSrcE    = ifa.PCSrcE;
    assign ifb.CntClr    = ifa.CntClr;

    hazard_scoreboard #(.CNT_W(16), .PC_REG(4'd15)) dut   (.clk(clk), .reset(reset), .hz(ifa.slave));
    hazard_scoreboard #(.CNT_W(2),  .PC_REG(4'd15)) dut_s (.clk(clk), .reset(reset), .hz(ifb.slave));

    typedef struct {
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
        int         sc, fc, sc2, fc2;
    } exp_t;

    typedef struct {
        logic [3:0] rd;
        bit         wr;
    } wr_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: list of retired E entries (newest first), plus event totals.
    wr_t hist[$];
    bit  m_first, m_bubble;
    int  m_sc, m_fc;

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic logic [1:0] fwd(input logic [3:0] ra);
        if (ra == 4'd15) return 2'b00;
        if (hist.size() > 0 && hist[0].wr && hist[0].rd == ra) return 2'b10;
        if (hist.size() > 1 && hist[1].wr && hist[1].rd == ra) return 2'b01;
        return 2'b00;
    endfunction

    task automatic mreset();
        hist.delete();
        m_first  = 1'b1;
        m_bubble = 1'b0;
        m_sc     = 0;
        m_fc     = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("ForwardAE",   32'(ifa.ForwardAE),  32'(e.fa));
            chk("ForwardBE",   32'(ifa.ForwardBE),  32'(e.fb));
            chk("StallF",      32'(ifa.StallF),     32'(e.sf));
            chk("StallD",      32'(ifa.StallD),     32'(e.sd));
            chk("FlushD",      32'(ifa.FlushD),     32'(e.fd));
            chk("FlushE",      32'(ifa.FlushE),     32'(e.fe));
            chk("StallCount",  32'(ifa.StallCount), e.sc);
            chk("FlushCount",  32'(ifa.FlushCount), e.fc);
            chk("StallCount2", 32'(ifb.StallCount), e.sc2);
            chk("FlushCount2", 32'(ifb.FlushCount), e.fc2);
        end
    end

    // One cycle: drive inputs just after the edge, predict, then let the edge retire it.
    task automatic cyc(input bit r, input bit clr,
                       input logic [3:0] a1d, input logic [3:0] a2d,
                       input logic [3:0] a1e, input logic [3:0] a2e,
                       input logic [3:0] rd, input bit wr, input bit ld, input bit br);
        exp_t e;
        bit   live, wrq, ldq, brq, stl;
        reset         = r;
        ifa.CntClr    = clr;
        ifa.RA1D      = a1d;
        ifa.RA2D      = a2d;
        ifa.RA1E      = a1e;
        ifa.RA2E      = a2e;
        ifa.RdE       = rd;
        ifa.RegWriteE = wr;
        ifa.MemtoRegE = ld;
        ifa.PCSrcE    = br;
        if (r) mreset();
        live  = !r && !m_first && !m_bubble;
        wrq   = wr && live;
        ldq   = ld && live;
        brq   = br && live;
        stl   = ldq && (rd == a1d || rd == a2d);
        e.fa  = fwd(a1e);
        e.fb  = fwd(a2e);
        e.sf  = stl;
        e.sd  = stl;
        e.fd  = brq;
        e.fe  = stl || brq;
        e.sc  = m_sc;
        e.fc  = m_fc;
        e.sc2 = sat3(m_sc);
        e.fc2 = sat3(m_fc);
        expq.push_back(e);
        @(posedge clk);
        if (!r) begin
            wr_t w;
            w.rd = rd;
            w.wr = wrq;
            hist.push_front(w);
            if (hist.size() > 2) void'(hist.pop_back());
            m_bubble = e.fe;
            m_first  = 1'b0;
            if (clr) begin
                m_sc = 0;
                m_fc = 0;
            end else begin
                m_sc += int'(stl);
                m_fc += int'(brq);
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
    endtask

    function automatic logic [3:0] pick();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 4'd15 : 4'(v);
    endfunction

    initial begin
        reset = 1'b1;
        mreset();
        ifa.CntClr = 0; ifa.RA1D = 0; ifa.RA2D = 0; ifa.RA1E = 0; ifa.RA2E = 0;
        ifa.RdE = 0; ifa.RegWriteE = 0; ifa.MemtoRegE = 0; ifa.PCSrcE = 0;
        @(posedge clk); #1;

        // Reset with a load-use pattern on the inputs, then first post-reset E entry ignored.
        cyc(1, 0, 4'd3, 4'd0, 4'd3, 4'd3, 4'd3, 1, 1, 1);
        cyc(1, 0, 4'd3, 4'd0, 4'd3, 4'd3, 4'd3, 1, 1, 1);
        cyc(0, 0, 4'd3, 4'd0, 4'd3, 4'd3, 4'd3, 1, 1, 0);
        idle(); idle(); idle();

        // M then W forwarding, and PC never forwarded.
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 1, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 0, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 1, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 0, 0, 0);

        // M priority over W.
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 1, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 1, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd0, 0, 0, 0);

        // Load-use stalls once; flushed entry holding the same bits is a bubble.
        cyc(0, 0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd7, 1, 1, 0);
        cyc(0, 0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd7, 1, 1, 0);
        idle();

        // Redirect together with load-use, then the redirect bubble.
        cyc(0, 0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd7, 1, 1, 1);
        cyc(0, 0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd7, 1, 1, 1);
        idle();

        // Five stall events saturate the narrow counters.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd9, 1, 1, 0);
            idle();
        end
        idle();

        // Clear wins over a same-cycle stall.
        cyc(0, 1, 4'd9, 4'd0, 4'd0, 4'd0, 4'd9, 1, 1, 0);
        idle(); idle();

        // Reset mid-stream with a live M-stage writer.
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 1, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 0, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 1, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
                pick(), pick(), pick(), pick(), pick(),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0);
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard and forwarding controller that consumes the Decode→Execute pipeline register outputs and generates stall, flush and forwarding controls.
- Tracks in-flight destination registers in private Memory and Writeback slots.
- Squashes control bits of flushed or unstable Execute-stage entries, which the E-stage register passes through on flush and leaves undefined after reset.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of StallCount and FlushCount.
- PC_REG, 4'd15, register index never forwarded (PC reads).

Ports:
- clk  input  1  clock
- reset  input  1  reset
- RA1D  input  4  Decode source register 1
- RA2D  input  4  Decode source register 2
- RA1E  input  4  Execute source register 1
- RA2E  input  4  Execute source register 2
- RdE  input  4  Execute destination register
- RegWriteE  input  1  Execute writes Rd (condition-qualified)
- MemtoRegE  input  1  Execute instruction is a load
- PCSrcE  input  1  Execute redirects PC (taken branch or PC write)
- CntClr  input  1  synchronous clear of both counters
- ForwardAE  output  2  SrcA select: 00 register file, 01 Writeback result, 10 Memory ALU result
- ForwardBE  output  2  same encoding for SrcB
- StallF  output  1  hold PC
- StallD  output  1  hold F→D register
- FlushD  output  1  flush F→D register
- FlushE  output  1  flush D→E register
- StallCount  output  CNT_W  cycles with load-use stall
- FlushCount  output  CNT_W  taken redirects

Behaviour:
- reset: asynchronous, active-high; clock clk. reset clears all internal state.
- Internal state:
  - validE: 0 on reset, 1 after the first clk edge.
  - bubbleE: registered copy of FlushE, 0 on reset.
  - M slot: RdM, RegWriteM, MemtoRegM.
  - W slot: RdW, RegWriteW.
  - StallCount and FlushCount.
- Effective E controls: qE = validE & ~bubbleE. Then wrE = RegWriteE & qE, ldE = MemtoRegE & qE, brE = PCSrcE & qE. Raw E inputs are never used unqualified.
- Each clk edge:
  - M slot <= {RdE, wrE, ldE}.
  - W slot <= {RdM, RegWriteM}.
  - bubbleE <= FlushE.
  - validE <= 1.
- Reset values:
  - RegWriteM, RegWriteW, MemtoRegM = 0; RdM, RdW = 0.
  - Therefore ForwardAE = ForwardBE = 00.
  - StallF, StallD, FlushD, FlushE = 0.
  - Counters = 0.
- Forwarding, combinational from registered slots:
  - ForwardAE = 10 if RegWriteM & RdM==RA1E & RA1E!=PC_REG.
  - Else 01 if RegWriteW & RdW==RA1E & RA1E!=PC_REG.
  - Else 00.
  - M has priority over W when both match.
  - ForwardBE is identical, using RA2E.
- Load-use: ldStall = ldE & (RdE==RA1D | RdE==RA2D).
- Control outputs, combinational, zero latency:
  - StallF = StallD = ldStall.
  - FlushD = brE.
  - FlushE = ldStall | brE.
- Simultaneous ldStall and brE: all of StallF, StallD, FlushD and FlushE assert. The redirect discards the stalled instruction.
- Bubble rule: the entry following any FlushE cycle is a bubble.
  - It cannot forward, stall or flush, even if its RegWriteE/MemtoRegE/PCSrcE inputs are 1.
  - A load followed by a dependent instruction stalls exactly 1 cycle, never 2.
- Counters:
  - Each clk edge: if CntClr, clear to 0.
  - Else StallCount += ldStall and FlushCount += brE, each saturating at 2^CNT_W−1.
  - CntClr wins over a same-cycle event.
- Reset mid-operation: in-flight M/W entries are discarded. No forward or stall is issued until new entries propagate. The first post-reset E entry is ignored (validE=0).

Test Plan:
- Reset, then RegWriteE=1, MemtoRegE=1, RdE=3, RA1D=3 with undefined inputs in the first cycle → no StallF in cycle 0; all outputs 0 during reset.
- Cycle n: wrE, RdE=5. Cycle n+1: RA1E=5 → ForwardAE=10. Cycle n+2: RA2E=5 → ForwardBE=01. RdE=15 with RA1E=15 → ForwardAE=00.
- Back-to-back writes to R2 (M and W both R2), RA1E=2 → ForwardAE=10 (M priority).
- Load RdE=7, RA2D=7 → StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle, RegWriteE/MemtoRegE held at 1 by the flushed E register → no stall; StallCount=1.
- PCSrcE=1 with ldStall=1 in the same cycle → FlushD=FlushE=StallF=1. Next cycle, PCSrcE stays 1 (bubble) → FlushD=0; FlushCount=1, StallCount=1.
- CNT_W=2: 5 stall events → StallCount=3. CntClr together with a stall event → StallCount=0. Assert reset mid-stream with RegWriteM=1 → ForwardAE=00 immediately.
